cla_seq_add_ctrl: RTL and testbench

//   Multi-precision sequential adder controller. Accepts two NIBBLES*4-bit operands on a

---
 rtl/cla_seq_add_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cla_seq_add_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_add_ctrl.sv
// Sequential multi-precision adder: one 4-bit carry-lookahead slice
// walks the operands nibble by nibble behind valid/ready handshakes.
module cla_seq_add_ctrl #(
  parameter  int NIBBLES = 8,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0] sl_a, sl_b;
  logic [3:0] sl_g, sl_p;
  logic [3:0] sl_c;
  logic [3:0] sl_s;
  logic       sl_ci;
  logic       last;

  // State register plus datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign last = (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) ||
                (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // 4-bit lookahead slice; sl_c[i] is the carry out of bit i
  always_comb begin
    sl_a  = a_q[{idx_q, 2'b00} +: 4];
    sl_b  = b_q[{idx_q, 2'b00} +: 4];
    sl_ci = carry_q;
    sl_g  = sl_a & sl_b;
    sl_p  = sl_a | sl_b;
    sl_c[0] = sl_g[0]
            | (sl_p[0] & sl_ci);
    sl_c[1] = sl_g[1]
            | (sl_p[1] & sl_g[0])
            | (sl_p[1] & sl_p[0] & sl_ci);
    sl_c[2] = sl_g[2]
            | (sl_p[2] & sl_g[1])
            | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0]
               & sl_ci);
    sl_c[3] = sl_g[3]
            | (sl_p[3] & sl_g[2])
            | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1]
               & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1]
               & sl_p[0] & sl_ci);
    sl_s = sl_a ^ sl_b ^ {sl_c[2:0], sl_ci};
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          idx_d   = '0;
          carry_d = 1'b0;
        end else begin
          sum_d[{idx_q, 2'b00} +: 4] = sl_s;
          carry_d = sl_c[3];
          if (last) begin
            idx_d  = '0;
            cout_d = sl_c[3];
            ovf_d  = sl_c[2] ^ sl_c[3];
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          idx_d   = '0;
          carry_d = 1'b0;
        end
      end
      default: begin
        idx_d   = '0;
        carry_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Bench for cla_seq_add_ctrl: directed vector table, corner
// sequences, and random traffic against an arithmetic model.
module tb_cla_seq_add_ctrl;

  localparam int N = 8;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  cla_seq_add_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Handshake one request; returns at the negedge after acceptance
  task automatic start_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb,
                          input logic tc);
    @(negedge clk);
    chk("start.in_ready", in_ready, 1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic tc,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo,
                        input bit hold);
    int lat;
    start_op(ta, tb, tc);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, lat, N);
    chk({nm, ".sum"}, sum, es);
    chk({nm, ".cout"}, cout, ec);
    chk({nm, ".ovf"}, ovf, eo);
    chk({nm, ".busy"}, busy, 1);
    if (!hold) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, ".in_ready"}, in_ready, 1);
      chk({nm, ".out_valid"}, out_valid, 0);
    end
  endtask

  logic [W-1:0] ea, eb, keep;
  logic         ec;
  logic [W:0]   full;
  logic         eovf;
  int           k, ops, cyc;
  bit           pending, deliver;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0,
                32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0,
                32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b1,
                32'hACF13569, 1'b0, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000003, 1'b0,
                32'h00000008, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0,
                32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1,
                32'h00000001, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a,
             vecs[i].b, vecs[i].cin, vecs[i].sum,
             vecs[i].cout, vecs[i].ovf, 1'b0);
    end

    // Backpressure: result held while consumer stalls
    run_op("bp", 32'h7FFFFFFF, 32'h00000001, 1'b0,
           32'h80000000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.out_valid", out_valid, 1);
      chk("bp.sum", sum, 32'h80000000);
      chk("bp.in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.rel_in_ready", in_ready, 1);
    chk("bp.rel_busy", busy, 0);
    chk("bp.keep_sum", sum, 32'h80000000);

    // Abort while idx==3
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.in_ready", in_ready, 1);
    chk("abort.busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort.no_valid", out_valid, 0);
    end
    run_op("abort.next", 32'h5, 32'h3, 1'b0,
           32'h8, 1'b0, 1'b0, 1'b0);

    // Abort together with out_ready in DONE
    run_op("abd", 32'h1, 32'h1, 1'b0,
           32'h2, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abd.out_valid", out_valid, 0);
    chk("abd.in_ready", in_ready, 1);

    // Asynchronous reset mid-RUN
    start_op(32'h0F0F0F0F, 32'h01010101, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.in_ready", in_ready, 1);
    chk("arst.busy", busy, 0);
    chk("arst.sum", sum, 0);
    chk("arst.cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("arst.next", 32'hFFFFFFFF, 32'hFFFFFFFF,
           1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

    // Random traffic, in_valid held, random out_ready
    pending = 0;
    deliver = 0;
    ops = 0;
    cyc = 0;
    k = 0;
    while (ops < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (deliver) begin
        pending = 0;
        deliver = 0;
        ops++;
      end
      if (!pending) begin
        chk("rnd.in_ready", in_ready, 1);
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        out_ready = 1'b0;
        ea = a;
        eb = b;
        ec = cin;
        full = {1'b0, ea} + {1'b0, eb} + W'(ec);
        eovf = (ea[W-1] == eb[W-1]) &&
               (full[W-1] != ea[W-1]);
        pending = 1;
        k = -1;
      end else begin
        k++;
        if (k == 0) begin
          a = $urandom;
          b = $urandom;
          cin = 1'($urandom_range(0, 1));
        end
        chk("rnd.out_valid", out_valid, (k >= N));
        if (out_valid) begin
          chk("rnd.sum", sum, full[W-1:0]);
          chk("rnd.cout", cout, full[W]);
          chk("rnd.ovf", ovf, eovf);
          chk("rnd.in_ready_done", in_ready, 0);
        end
        out_ready = 1'($urandom_range(0, 1));
        deliver = out_valid && out_ready;
      end
    end
    chk("rnd.ops", ops, 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    keep = sum;
    @(negedge clk);
    chk("end.idle", in_ready, 1);
    chk("end.keep", sum, keep);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
